// File: rtl/joy_db15_tx.sv
// joy_db15_tx
//   Device-side responder for the DB15 serial joystick link. Emulates the
//   74HC165-style chain the host reader polls: a low LOAD snapshots both
//   players' buttons (inverted, pressed = 0), then every rising host clock
//   presents the next bit on joy_data, player1[0] first.
//
// Ports
//   clk, reset_n       system clock, async active-low reset
//   joy_clk, joy_load  host shift clock / active-low load (async to clk)
//   joy_data           serial data to host, straight from sr_q[0]
//   player1, player2   active-high button state, 16 bits each
//   frame_ok           1-cycle pulse: load began after exactly CHAIN_BITS shifts
//   frame_short        1-cycle pulse: load began after 1..CHAIN_BITS-1 shifts
//   bit_count          shifts since last load, saturates at CHAIN_BITS
module joy_db15_tx #(
    parameter int CHAIN_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        joy_clk,
    input  logic        joy_load,
    output logic        joy_data,
    input  logic [15:0] player1,
    input  logic [15:0] player2,
    output logic        frame_ok,
    output logic        frame_short,
    output logic [5:0]  bit_count
);

    localparam logic [5:0] CHAIN_CNT = 6'(CHAIN_BITS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, load_sync_q;
    logic                   clk_hist_q, clk_rise_q;
    logic                   load_hist_q, load_fall_q;

    state_t                 state_q, state_d;
    logic [CHAIN_BITS-1:0]  sr_q, sr_d;
    logic [5:0]             cnt_q, cnt_d;
    logic                   ok_q, ok_d, short_q, short_d;

    // Synchronizers plus a history flop. The edge pulses are registered so
    // they line up with load_hist_q, which is used as the load level: the
    // cycle that sees load_fall_q also sees load_hist_q == 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '0;
            load_sync_q <= '1;
            clk_hist_q  <= 1'b0;
            clk_rise_q  <= 1'b0;
            load_hist_q <= 1'b1;
            load_fall_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], joy_load};
            clk_hist_q  <= clk_sync_q[SYNC_STAGES-1];
            clk_rise_q  <= clk_sync_q[SYNC_STAGES-1] & ~clk_hist_q;
            load_hist_q <= load_sync_q[SYNC_STAGES-1];
            load_fall_q <= ~load_sync_q[SYNC_STAGES-1] & load_hist_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '1;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            short_q <= short_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ok_d    = 1'b0;
        short_d = 1'b0;
        if (!load_hist_q) begin
            // Load low dominates any clock edge seen in the same cycle.
            state_d = LOAD;
            sr_d    = ~(CHAIN_BITS'({player2, player1}));
            cnt_d   = '0;
            if (load_fall_q) begin
                ok_d    = (cnt_q == CHAIN_CNT);
                short_d = (cnt_q != 6'd0) && (cnt_q < CHAIN_CNT);
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                LOAD: state_d = SHIFT;
                SHIFT: if (clk_rise_q) begin
                    sr_d  = {1'b1, sr_q[CHAIN_BITS-1:1]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q + 6'd1 == CHAIN_CNT) state_d = DONE;
                end
                DONE: if (clk_rise_q) sr_d = {1'b1, sr_q[CHAIN_BITS-1:1]};
                default: state_d = IDLE;
            endcase
        end
    end

    assign joy_data    = sr_q[0];
    assign frame_ok    = ok_q;
    assign frame_short = short_q;
    assign bit_count   = cnt_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
module tb_joy_db15_tx;
    logic        clk = 1'b0;
    logic        reset_n, joy_clk, joy_load, joy_data;
    logic [15:0] player1, player2;
    logic        frame_ok, frame_short;
    logic [5:0]  bit_count;

    int n_cmp = 0;
    int n_err = 0;
    int ok_seen = 0;
    int short_seen = 0;
    int ok0, sh0;
    logic [63:0] w, w2;

    always #5 clk = ~clk;

    joy_db15_tx dut (
        .clk(clk), .reset_n(reset_n), .joy_clk(joy_clk), .joy_load(joy_load),
        .joy_data(joy_data), .player1(player1), .player2(player2),
        .frame_ok(frame_ok), .frame_short(frame_short), .bit_count(bit_count)
    );

    // Count cycles each frame pulse is high (value before the edge update).
    always @(posedge clk) begin
        if (frame_ok)    ok_seen++;
        if (frame_short) short_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        joy_clk = 1'b1; cyc(6);
        joy_clk = 1'b0; cyc(6);
    endtask

    task automatic do_load();
        ok0 = ok_seen; sh0 = short_seen;
        joy_load = 1'b0; cyc(8);
        joy_load = 1'b1; cyc(8);
    endtask

    // Read the current bit, then clock the next one out.
    task automatic shift_n(input int n, output logic [63:0] word);
        word = '0;
        for (int i = 0; i < n; i++) begin
            word[i] = joy_data;
            pulse();
        end
    endtask

    initial begin
        reset_n = 1'b0; joy_clk = 1'b0; joy_load = 1'b1;
        player1 = 16'h0; player2 = 16'h0;
        cyc(2);
        ok0 = ok_seen; sh0 = short_seen;

        // Reset held while the host clocks
        repeat (5) pulse();
        chk("rst_data", 64'(joy_data), 64'd1);
        chk("rst_cnt", 64'(bit_count), 64'd0);
        chk("rst_pulses", 64'((ok_seen - ok0) + (short_seen - sh0)), 64'd0);

        // Idle: clocks before any load are ignored
        reset_n = 1'b1; cyc(4);
        pulse(); pulse();
        chk("idle_data", 64'(joy_data), 64'd1);
        chk("idle_cnt", 64'(bit_count), 64'd0);

        // Full frame
        player1 = 16'h0005; player2 = 16'h8001;
        do_load();
        chk("first_load_pulses", 64'((ok_seen - ok0) + (short_seen - sh0)), 64'd0);
        shift_n(16, w);
        chk("cnt16", 64'(bit_count), 64'd16);
        shift_n(16, w2);
        chk("full_word", {32'd0, w2[15:0], w[15:0]}, 64'h7FFE_FFFA);
        chk("full_tail", 64'(joy_data), 64'd1);
        chk("full_cnt", 64'(bit_count), 64'd32);
        do_load();
        chk("full_ok", 64'(ok_seen - ok0), 64'd1);
        chk("full_short", 64'(short_seen - sh0), 64'd0);

        // Overrun: 40 clocks, extra bits read released, count saturates
        shift_n(40, w);
        chk("ovr_word", {32'd0, w[31:0]}, 64'h7FFE_FFFA);
        chk("ovr_extra", 64'(w[39:32]), 64'hFF);
        chk("ovr_cnt", 64'(bit_count), 64'd32);
        do_load();
        chk("ovr_ok", 64'(ok_seen - ok0), 64'd1);

        // Short frame
        shift_n(10, w);
        chk("short_bits", 64'(w[9:0]), 64'h3FA);
        chk("short_cnt", 64'(bit_count), 64'd10);
        do_load();
        chk("short_pulse", 64'(short_seen - sh0), 64'd1);
        chk("short_no_ok", 64'(ok_seen - ok0), 64'd0);
        chk("short_restart", 64'(joy_data), 64'd0);
        chk("short_cnt0", 64'(bit_count), 64'd0);

        // Snapshot hold: input change mid-frame is not seen
        player1 = 16'h0000;
        do_load();
        shift_n(3, w);
        player1 = 16'hFFFF;
        shift_n(13, w2);
        chk("snap_p1", 64'({w2[12:0], w[2:0]}), 64'hFFFF);
        shift_n(16, w);
        do_load();
        chk("snap_ok", 64'(ok_seen - ok0), 64'd1);
        shift_n(16, w);
        chk("snap_next", 64'(w[15:0]), 64'h0000);

        // Collision: clock edge while load low does not shift
        player1 = 16'h0002;
        joy_load = 1'b0; cyc(8);
        pulse();
        joy_load = 1'b1; cyc(8);
        chk("coll_cnt", 64'(bit_count), 64'd0);
        chk("coll_bit0", 64'(joy_data), 64'd1);
        pulse();
        chk("coll_bit1", 64'(joy_data), 64'd0);
        chk("coll_cnt1", 64'(bit_count), 64'd1);

        // Async reset mid-shift, no shifting until a new load
        player1 = 16'hFFFF; player2 = 16'hFFFF;
        do_load();
        shift_n(12, w);
        chk("pre_rst_cnt", 64'(bit_count), 64'd12);
        chk("pre_rst_data", 64'(joy_data), 64'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_data", 64'(joy_data), 64'd1);
        chk("async_rst_cnt", 64'(bit_count), 64'd0);
        cyc(2);
        reset_n = 1'b1; cyc(4);
        for (int i = 0; i < 4; i++) begin
            pulse();
            chk("post_rst_data", 64'(joy_data), 64'd1);
        end
        chk("post_rst_cnt", 64'(bit_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Device-side responder for the DB15 serial joystick link: the shift-register end that the host-side DB15 reader polls over the USER port. It snapshots the button state of two players when the host drives LOAD low. It then presents one bit per host clock edge on DATA, so the adapter's 74HC165-style chain can be emulated in an FPGA test rig or a multi-board setup. It sits on the USER_IN/USER_OUT pins opposite the host reader; host clock and load are asynchronous to `clk`.

## Interface
Parameters:
- `CHAIN_BITS`, 32: total bits shifted per frame (16 per player).
- `SYNC_STAGES`, 2: synchronizer depth on `joy_clk` and `joy_load`.

Ports:
- `clk` in 1: system clock, 40–50 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `joy_clk` in 1: host shift clock, async; a bit advances on its rising edge.
- `joy_load` in 1: host load, async, active-low; low means parallel load.
- `joy_data` out 1: serial data to host, active-low (pressed = 0).
- `player1` in 16: button state, active-high, bit order `{L,S,F,E,D,C,B,A,U,D,L,R}` in [11:0]; bits [15:12] are spare.
- `player2` in 16: same layout as `player1`.
- `frame_ok` out 1: one-cycle pulse when a load starts after exactly `CHAIN_BITS` shifts.
- `frame_short` out 1: one-cycle pulse when a load starts after 1..`CHAIN_BITS`-1 shifts.
- `bit_count` out 6: number of shifts since the last load, saturating at `CHAIN_BITS`.

## Operation
- Synchronize `joy_clk` and `joy_load` through `SYNC_STAGES` flops each, plus one history flop for edge detection.
- Shift register `sr[CHAIN_BITS-1:0]` holds the inverted snapshot `~{player2, player1}`.
- `joy_data` is driven directly from the `sr[0]` register.
- States:
  - IDLE: after reset, before the first load. `joy_data`=1; clock edges are ignored.
  - LOAD: entered while synchronized load=0. Every cycle, `sr` reloads from the inputs and `bit_count` is forced to 0.
  - SHIFT: entered when synchronized load goes 0→1. On each synchronized `joy_clk` rising edge, `sr` shifts right with 1 filling the MSB, and `bit_count` increments.
  - DONE: entered when `bit_count` reaches `CHAIN_BITS`. Further edges shift in 1s, so `joy_data`=1. `bit_count` holds.
- Frame check: on the load falling edge, pulse `frame_ok` if `bit_count`==`CHAIN_BITS`, or `frame_short` if 0<`bit_count`<`CHAIN_BITS`. Neither pulses when `bit_count`==0.
- A load fall in any state enters LOAD.
- If load is low and a clock edge occur in the same cycle, load wins: no shift, no count.
- Wire bit order: the first bit after load is `player1[0]`, continuing through `player1[15]`, then `player2[0]`..`player2[15]`.
- Input changes are not seen while in SHIFT or DONE; the snapshot is the last LOAD-cycle value.

## Timing
- Reset values: `joy_data`=1, `sr`=all 1s, `bit_count`=0, `frame_ok`=`frame_short`=0, state IDLE.
- Clock/load input latency: a pin change is visible after `SYNC_STAGES` cycles. The edge is detected one cycle later, and `joy_data` updates on the following edge. Pin-to-`joy_data` latency is `SYNC_STAGES`+2 cycles (4 at default).
- In LOAD, `joy_data` reflects `~player1[0]` within `SYNC_STAGES`+2 cycles of the load fall. It tracks input changes with 1 cycle latency while load stays low.
- Host requirements:
  - high and low phases of `joy_clk` ≥ `SYNC_STAGES`+3 cycles;
  - `joy_load` low ≥ `SYNC_STAGES`+2 cycles.
  - Shorter pulses are undefined; they may be missed but must never corrupt state.
- Frame pulses assert 1 cycle after the synchronized load fall.
- Reset assertion mid-shift returns to IDLE immediately. After `reset_n` deasserts, nothing shifts until a new load.

## Test plan
- Reset then idle: hold `reset_n`=0, pulse `joy_clk` ×5 → `joy_data`=1, `bit_count`=0, no frame pulses.
- Full frame: `player1`=16'h0005, `player2`=16'h8001, load, then 32 clocks → wire sequence `0,1,0,1,1…1` for P1, then P2 bit0=0, bits1–14=1, bit15=0. The next load pulses `frame_ok` once; `bit_count`=32 before the reload.
- Overrun: 40 clocks after load → bits 33–40 read 1, `bit_count` holds at 32, and the next load gives `frame_ok`.
- Short frame: 10 clocks then load → `frame_short`=1 for exactly one cycle and `frame_ok`=0; the reload restarts at `player1[0]`.
- Snapshot hold: change `player1` from 0 to 16'hFFFF after the 3rd clock → bits 4–16 still read 1 (released); the next frame reads all 0 for P1.
- Collision and async reset: a clock edge while load is low → no shift. `reset_n` low after 12 shifts, then release and shift 4 clocks without a load → `joy_data`=1 throughout.
